aibcr3aux_osc_en_seq: RTL and testbench

Power-up/power-down sequencer directly upstream of the aux oscillator clock-gate synchronizer.
- Receives a software/PMA oscillator request.
- Powers the oscillator and waits a programmable settle interval before raising the gate enable consumed by the clock-gate sync's `en` input.
- On release, drops the gate enable first, then holds oscillator power for a drain interval so the gate's 2-FF synchronizer closes on a live clock.
- Returns a level acknowledge to the requester.

---
 rtl/aibcr3aux_osc_pkg.sv | 25 ++
 rtl/aibcr3aux_osc_en_seq.sv | 111 +++++++++++
 tb/tb_aibcr3aux_osc_en_seq.sv | 138 +++++++++++++
 3 files changed

// File: rtl/aibcr3aux_osc_pkg.sv
// Shared types and constants for the aux oscillator enable sequencer.
package aibcr3aux_osc_pkg;

    // Sequencer states; the encoding is visible on the debug state port.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ON     = 2'd2,
        DRAIN  = 2'd3
    } osc_state_e;

    // Default settle-counter width and post-gate power hold time.
    localparam int SETTLE_W_DEF  = 10;
    localparam int DRAIN_CYC_DEF = 8;

    // The gate's 2-FF synchronizer needs a few live clock edges to close,
    // so power must be held at least this long after en falls.
    localparam int MIN_DRAIN_CYC = 4;

    // busy marks the two transitional states.
    function automatic logic busy_of(input osc_state_e s);
        return (s == SETTLE) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/aibcr3aux_osc_en_seq.sv
// Power-up/power-down sequencer feeding the aux oscillator clock-gate sync.
// Power comes up first and the gate opens after a settle interval; on release
// the gate closes first and power is held for a drain interval.
module aibcr3aux_osc_en_seq
    import aibcr3aux_osc_pkg::*;
#(
    parameter int SETTLE_W  = SETTLE_W_DEF,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic                ckin,
    input  logic                rst,
    input  logic                osc_req,
    input  logic [SETTLE_W-1:0] settle_cnt,
    output logic                osc_pwr_en,
    output logic                en,
    output logic                osc_ack,
    output logic                busy,
    output logic [1:0]          state
);

    localparam logic [SETTLE_W-1:0] CNT_ONE    = SETTLE_W'(1);
    localparam logic [SETTLE_W-1:0] DRAIN_LOAD = SETTLE_W'(DRAIN_CYC);

    // Reject drain lengths the gate synchronizer cannot tolerate or the
    // counter cannot hold.
    generate
        if (DRAIN_CYC < MIN_DRAIN_CYC) begin : g_drain_too_short
            $error("DRAIN_CYC must be at least MIN_DRAIN_CYC");
        end
        if (DRAIN_CYC >= (2 ** SETTLE_W)) begin : g_drain_too_long
            $error("DRAIN_CYC must fit in the SETTLE_W-bit counter");
        end
    endgenerate

    osc_state_e          state_q, state_d;
    logic [SETTLE_W-1:0] cnt_q,   cnt_d;
    logic                pwr_q, en_q, busy_q;

    // Next-state and counter update.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (osc_req) begin
                    state_d = SETTLE;
                    // A zero settle request still spends one cycle in SETTLE.
                    cnt_d   = (settle_cnt == '0) ? CNT_ONE : settle_cnt;
                end
            end
            SETTLE: begin
                if (!osc_req) begin
                    // Abort before the gate opened: no drain needed.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = ON;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            ON: begin
                if (!osc_req) begin
                    state_d = DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (osc_req) begin
                    // Oscillator is still powered, so reopen without settling.
                    state_d = ON;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and outputs; outputs decode next state so they move with it.
    always_ff @(posedge ckin) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pwr_q   <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pwr_q   <= (state_d != IDLE);
            en_q    <= (state_d == ON);
            busy_q  <= busy_of(state_d);
        end
    end

    assign osc_pwr_en = pwr_q;
    assign en         = en_q;
    assign osc_ack    = en_q;
    assign busy       = busy_q;
    assign state      = state_q;

endmodule

// File: tb/tb_aibcr3aux_osc_en_seq.sv
// Directed bench for the aux oscillator enable sequencer. Each vector drives
// the inputs for one edge and queues the hand-derived state expected after
// that edge; a monitor pops and compares just after every rising edge.
module tb_aibcr3aux_osc_en_seq;

    logic       ckin = 1'b0;
    logic       rst = 1'b1;
    logic       osc_req = 1'b0;
    logic [9:0] settle_cnt = '0;
    logic       osc_pwr_en, en, osc_ack, busy;
    logic [1:0] state;

    typedef struct packed {
        int         id;
        logic [1:0] st;
        logic       pwr;
        logic       en;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   vec_id   = 0;

    aibcr3aux_osc_en_seq #(
        .SETTLE_W (10),
        .DRAIN_CYC(8)
    ) dut (
        .ckin      (ckin),
        .rst       (rst),
        .osc_req   (osc_req),
        .settle_cnt(settle_cnt),
        .osc_pwr_en(osc_pwr_en),
        .en        (en),
        .osc_ack   (osc_ack),
        .busy      (busy),
        .state     (state)
    );

    always #5 ckin = ~ckin;

    task automatic check(input string name, input int id,
                         input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%0h required=%0h", name, id, act, req);
        end
    endtask

    // Drive n identical vectors; es is the state expected after each edge.
    task automatic step(input logic r, input logic req, input logic [9:0] sc,
                        input logic [1:0] es, input int n = 1);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge ckin);
            rst        = r;
            osc_req    = req;
            settle_cnt = sc;
            e.id   = vec_id;
            e.st   = es;
            e.pwr  = (es != 2'd0);
            e.en   = (es == 2'd2);
            e.busy = (es == 2'd1) || (es == 2'd3);
            exp_q.push_back(e);
            vec_id++;
        end
    endtask

    // Monitor: compare the DUT just after each edge against the queued vector.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge ckin);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("state",      e.id, 32'(state),      32'(e.st));
                check("osc_pwr_en", e.id, 32'(osc_pwr_en), 32'(e.pwr));
                check("en",         e.id, 32'(en),         32'(e.en));
                check("osc_ack",    e.id, 32'(osc_ack),    32'(e.en));
                check("busy",       e.id, 32'(busy),       32'(e.busy));
                check("en_implies_pwr", e.id, 32'(!en || osc_pwr_en), 32'd1);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        // Reset held with a pending request: everything stays low.
        step(1, 1, 10'd4, 2'd0, 3);
        // Release: power at the first edge, gate 4 edges later.
        step(0, 1, 10'd4, 2'd1, 4);
        step(0, 1, 10'd4, 2'd2, 3);
        // Release request: gate drops at once, power held 8 edges.
        step(0, 0, 10'd4, 2'd3, 8);
        step(0, 0, 10'd4, 2'd0, 2);
        // Abort during a long settle: gate never opens, no drain.
        step(0, 1, 10'd100, 2'd1, 5);
        step(0, 0, 10'd100, 2'd0, 2);
        // settle_cnt=0 acts as 1: gate one edge after power.
        step(0, 1, 10'd0, 2'd1, 1);
        step(0, 1, 10'd0, 2'd2, 2);
        // Re-request 3 edges into drain: straight back to ON.
        step(0, 0, 10'd0, 2'd3, 3);
        step(0, 1, 10'd0, 2'd2, 2);
        // Full drain again.
        step(0, 0, 10'd0, 2'd3, 8);
        step(0, 0, 10'd0, 2'd0, 1);
        // settle_cnt changed mid-settle is ignored: interval stays 2.
        step(0, 1, 10'd2, 2'd1, 1);
        step(0, 1, 10'd50, 2'd1, 1);
        step(0, 1, 10'd50, 2'd2, 2);
        // Reset in ON: gate and power drop on the same edge.
        step(1, 1, 10'd50, 2'd0, 1);
        // Reset in DRAIN: power drops without finishing the drain.
        step(0, 1, 10'd1, 2'd1, 1);
        step(0, 1, 10'd1, 2'd2, 1);
        step(0, 0, 10'd1, 2'd3, 1);
        step(1, 0, 10'd1, 2'd0, 1);
        step(0, 0, 10'd1, 2'd0, 2);

        // Bounded wait for the monitor to consume every queued vector.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge ckin);
        #2;
        check("queue_empty", vec_id, 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
